string_match_engine: RTL and testbench

Parametrised successor to the fixed 19-character string processor. It slides a STR_LEN-byte window over the byte stream delivered by cmd_parser. For each window position it builds one padded single-block MD5 message and issues it to the pipelined MD5 core. It compares each returned digest with the target hash, latches the first match, reports that match's byte position, and lets cmd_parser read the matched string back one character at a time.

---
 rtl/md5_match_pkg.sv | 49 ++++
 rtl/string_match_engine_char_window.sv | 67 ++++++
 rtl/string_match_engine.sv | 214 +++++++++++++++++++++
 tb/tb_string_match_engine.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/md5_match_pkg.sv
`default_nettype none
// ============================================================================
// Module      : md5_match_pkg
// Description : Shared types and helpers for the MD5 string match engine.
//               Holds block/digest widths, the control state encoding, a
//               32-bit byte swap and the single-block MD5 padding builder.
// Revision    : 1.0 - initial release
// ============================================================================
package md5_match_pkg;

    localparam int MD5_BLK_W   = 512;
    localparam int DIGEST_W    = 128;
    localparam int STR_LEN_MAX = 55;
    // Message bytes 0..55 sit below the 64-bit length field.
    localparam int WIN_MAX_W   = 448;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FILL  = 3'd1,
        S_RUN   = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    function automatic logic [31:0] bswap32(input logic [31:0] x);
        return {x[7:0], x[15:8], x[23:16], x[31:24]};
    endfunction

    // Builds a padded one-block message: window bytes, 0x80 marker, zero
    // fill, then the bit length as a little-endian 64-bit value.
    function automatic logic [MD5_BLK_W-1:0] pad_block(
        input logic [WIN_MAX_W-1:0] window,
        input int                   str_len
    );
        logic [MD5_BLK_W-1:0] blk;
        blk = '0;
        for (int i = 0; i < 56; i++) begin
            if (i < str_len) begin
                blk[8*i +: 8] = window[8*i +: 8];
            end else if (i == str_len) begin
                blk[8*i +: 8] = 8'h80;
            end
        end
        blk[MD5_BLK_W-1 -: 64] = 64'(str_len) << 3;
        return blk;
    endfunction

endpackage
`default_nettype wire

// File: rtl/string_match_engine_char_window.sv
`default_nettype none
// ============================================================================
// Module      : char_window
// Description : STR_LEN-byte sliding window over a byte stream. Byte 0 is the
//               oldest byte. Tracks how many bytes have arrived since clear
//               and flags when the window holds a complete string.
//   clk, rst       clock, asynchronous active-high reset
//   i_clear        synchronous clear of window, fill count and full flag
//   i_shift        accept i_data into the window this cycle
//   i_data         incoming byte
//   o_window_next  window contents after this cycle's shift
//   o_full_next    window will be complete after this cycle's shift
// Revision    : 1.0 - initial release
// ============================================================================
module char_window
    import md5_match_pkg::*;
#(
    parameter int STR_LEN = 19
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_clear,
    input  logic                 i_shift,
    input  logic [7:0]           i_data,
    output logic [8*STR_LEN-1:0] o_window_next,
    output logic                 o_full_next
);

    localparam int c_cnt_w = $clog2(STR_LEN + 1);

    logic [8*STR_LEN-1:0] r_win;
    logic [c_cnt_w-1:0]   r_cnt;
    logic                 r_full;
    logic [8*STR_LEN-1:0] w_shifted;

    // Newest byte enters at the top so byte 0 always holds the oldest.
    generate
        if (STR_LEN == 1) begin : g_single
            assign w_shifted = i_data;
        end else begin : g_multi
            assign w_shifted = {i_data, r_win[8*STR_LEN-1:8]};
        end
    endgenerate

    assign o_window_next = i_shift ? w_shifted : r_win;
    assign o_full_next   = r_full || (i_shift && (r_cnt == c_cnt_w'(STR_LEN - 1)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_win  <= '0;
            r_cnt  <= '0;
            r_full <= 1'b0;
        end else if (i_clear) begin
            r_win  <= '0;
            r_cnt  <= '0;
            r_full <= 1'b0;
        end else if (i_shift) begin
            r_win  <= w_shifted;
            r_full <= o_full_next;
            if (!r_full) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/string_match_engine.sv
`default_nettype none
// ============================================================================
// Module      : string_match_engine
// Description : Slides a STR_LEN-byte window over the command stream, issues
//               one padded MD5 block per window position to a pipelined MD5
//               core, compares returned digests with the target hash and
//               latches the first matching string for character readout.
//   clk_96mhz / reset       clock, asynchronous active-high reset
//   proc_start              start pulse (honoured in IDLE/DONE)
//   proc_num_bytes          stream length, sampled on proc_start
//   proc_data(_valid)       stream bytes
//   proc_match_char_next    advance readout character
//   proc_target_hash        digest to find, [127:120] is byte 0
//   proc_done / proc_match  run complete / match found (levels)
//   proc_byte_pos           stream index of the matched string
//   proc_match_char         current readout character
//   m_out / valid_out       block to the MD5 core
//   m_in / valid_in         block echoed by the core with its digest
//   a_in..d_in              MD5 chaining words of the result
// Revision    : 1.0 - initial release
// ============================================================================
module string_match_engine
    import md5_match_pkg::*;
#(
    parameter int STR_LEN = 19,
    parameter int POS_W   = 16,
    parameter int MD5_LAT = 65
) (
    input  logic                 clk_96mhz,
    input  logic                 reset,
    input  logic                 proc_start,
    input  logic [POS_W-1:0]     proc_num_bytes,
    input  logic [7:0]           proc_data,
    input  logic                 proc_data_valid,
    input  logic                 proc_match_char_next,
    input  logic [DIGEST_W-1:0]  proc_target_hash,
    output logic                 proc_done,
    output logic                 proc_match,
    output logic [POS_W-1:0]     proc_byte_pos,
    output logic [7:0]           proc_match_char,
    output logic [MD5_BLK_W-1:0] m_out,
    output logic                 valid_out,
    input  logic [MD5_BLK_W-1:0] m_in,
    input  logic                 valid_in,
    input  logic [31:0]          a_in,
    input  logic [31:0]          b_in,
    input  logic [31:0]          c_in,
    input  logic [31:0]          d_in
);

    localparam int c_win_w = 8 * STR_LEN;
    localparam int c_idx_w = (STR_LEN > 1) ? $clog2(STR_LEN) : 1;

    generate
        if (STR_LEN < 1 || STR_LEN > STR_LEN_MAX || MD5_LAT < 1) begin : g_param_check
            $error("string_match_engine: STR_LEN must be 1..55 and MD5_LAT at least 1");
        end
    endgenerate

    state_t               r_state;
    state_t               w_state_next;

    logic [POS_W-1:0]     r_expected;
    logic [POS_W-1:0]     r_issued;
    logic [POS_W-1:0]     r_result;
    logic                 r_match;
    logic [POS_W-1:0]     r_byte_pos;
    logic [c_win_w-1:0]   r_match_str;
    logic [c_idx_w-1:0]   r_idx;
    logic                 r_valid_out;
    logic [MD5_BLK_W-1:0] r_m_out;

    logic                 w_start;
    logic                 w_short;
    logic                 w_accept;
    logic                 w_full_next;
    logic [c_win_w-1:0]   w_window_next;
    logic                 w_issue;
    logic                 w_last_issue;
    logic                 w_result;
    logic                 w_last_result;
    logic [DIGEST_W-1:0]  w_digest;
    logic                 w_echo_ok;
    logic                 w_hit;
    logic                 w_first_hit;

    assign w_start  = proc_start && (r_state == S_IDLE || r_state == S_DONE);
    assign w_short  = proc_num_bytes < POS_W'(STR_LEN);
    // Only FILL and RUN consume bytes; anything past the last window lands
    // in DRAIN/DONE and is dropped.
    assign w_accept = proc_data_valid && (r_state == S_FILL || r_state == S_RUN);

    char_window #(
        .STR_LEN(STR_LEN)
    ) u_char_window (
        .clk          (clk_96mhz),
        .rst          (reset),
        .i_clear      (w_start),
        .i_shift      (w_accept),
        .i_data       (proc_data),
        .o_window_next(w_window_next),
        .o_full_next  (w_full_next)
    );

    assign w_issue      = w_accept && w_full_next;
    assign w_last_issue = w_issue && ((r_issued + 1'b1) == r_expected);

    // Results are counted only while a run is active, so digests still in
    // flight from an aborted run fall on the floor in IDLE.
    assign w_result      = valid_in && (r_state == S_RUN || r_state == S_DRAIN);
    assign w_last_result = w_result && ((r_result + 1'b1) == r_expected);

    assign w_digest = {bswap32(a_in), bswap32(b_in), bswap32(c_in), bswap32(d_in)};
    // A hit also requires the echoed block to carry this engine's padding,
    // so a foreign or corrupted block can never be reported as a match.
    assign w_echo_ok   = (m_in == pad_block(m_in[WIN_MAX_W-1:0], STR_LEN));
    assign w_hit       = w_result && w_echo_ok && (w_digest == proc_target_hash);
    assign w_first_hit = w_hit && !r_match;

    always_ff @(posedge clk_96mhz or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (w_start) begin
                    w_state_next = w_short ? S_DONE : S_FILL;
                end
            end
            S_FILL: begin
                if (w_last_issue) begin
                    w_state_next = S_DRAIN;
                end else if (w_issue) begin
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                if (w_last_issue) begin
                    w_state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_last_result) begin
                    w_state_next = S_DONE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_96mhz or posedge reset) begin
        if (reset) begin
            r_expected  <= '0;
            r_issued    <= '0;
            r_result    <= '0;
            r_match     <= 1'b0;
            r_byte_pos  <= '0;
            r_match_str <= '0;
            r_idx       <= '0;
            r_valid_out <= 1'b0;
            r_m_out     <= '0;
        end else begin
            r_valid_out <= w_issue;
            if (w_issue) begin
                r_m_out <= pad_block({{(WIN_MAX_W - c_win_w){1'b0}}, w_window_next}, STR_LEN);
            end

            if (w_start) begin
                r_expected <= w_short ? '0 : (proc_num_bytes - POS_W'(STR_LEN - 1));
                r_issued   <= '0;
                r_result   <= '0;
                r_match    <= 1'b0;
                r_byte_pos <= '0;
                r_idx      <= '0;
            end else begin
                if (w_issue) begin
                    r_issued <= r_issued + 1'b1;
                end
                if (w_result) begin
                    r_result <= r_result + 1'b1;
                end
                if (w_first_hit) begin
                    r_match     <= 1'b1;
                    r_byte_pos  <= r_result;
                    r_match_str <= m_in[c_win_w-1:0];
                    r_idx       <= '0;
                end else if (proc_match_char_next) begin
                    if (r_idx == c_idx_w'(STR_LEN - 1)) begin
                        r_idx <= '0;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
            end
        end
    end

    assign proc_done       = (r_state == S_DONE);
    assign proc_match      = r_match;
    assign proc_byte_pos   = r_byte_pos;
    assign proc_match_char = r_match ? r_match_str[{r_idx, 3'b000} +: 8] : 8'h00;
    assign valid_out       = r_valid_out;
    assign m_out           = r_m_out;

endmodule
`default_nettype wire

// File: tb/tb_string_match_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_string_match_engine
// Description : Self-checking bench for string_match_engine. A behavioural
//               MD5 core with fixed latency answers the engine; expected
//               blocks, match position and readout come from a reference
//               model built on byte queues and a plain MD5 function.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_string_match_engine;

    localparam int L3  = 3;
    localparam int LAT = 65;
    localparam logic [127:0] TARGET = 128'h900150983cd24fb0d6963f7d28e17f72;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT with STR_LEN = 3 ----------------
    logic         start3 = 1'b0;
    logic [15:0]  nb3 = '0;
    logic [7:0]   data3 = '0;
    logic         dv3 = 1'b0;
    logic         next3 = 1'b0;
    logic         done3, match3, vo3;
    logic [15:0]  pos3;
    logic [7:0]   char3;
    logic [511:0] mout3;
    logic [511:0] min3 = '0;
    logic         vi3 = 1'b0;
    logic [31:0]  a3 = '0, b3 = '0, c3 = '0, d3 = '0;

    string_match_engine #(.STR_LEN(L3), .POS_W(16), .MD5_LAT(LAT)) u_dut3 (
        .clk_96mhz(clk), .reset(rst), .proc_start(start3), .proc_num_bytes(nb3),
        .proc_data(data3), .proc_data_valid(dv3), .proc_match_char_next(next3),
        .proc_target_hash(TARGET), .proc_done(done3), .proc_match(match3),
        .proc_byte_pos(pos3), .proc_match_char(char3), .m_out(mout3), .valid_out(vo3),
        .m_in(min3), .valid_in(vi3), .a_in(a3), .b_in(b3), .c_in(c3), .d_in(d3)
    );

    // ---------------- DUT with STR_LEN = 19 ----------------
    logic         start19 = 1'b0;
    logic [15:0]  nb19 = '0;
    logic [7:0]   data19 = '0;
    logic         dv19 = 1'b0;
    logic         done19, match19, vo19;
    logic [15:0]  pos19;
    logic [7:0]   char19;
    logic [511:0] mout19;
    logic         zero1 = 1'b0;
    logic [511:0] zero512 = '0;
    logic [31:0]  zero32 = '0;

    string_match_engine #(.STR_LEN(19), .POS_W(16), .MD5_LAT(LAT)) u_dut19 (
        .clk_96mhz(clk), .reset(rst), .proc_start(start19), .proc_num_bytes(nb19),
        .proc_data(data19), .proc_data_valid(dv19), .proc_match_char_next(zero1),
        .proc_target_hash(TARGET), .proc_done(done19), .proc_match(match19),
        .proc_byte_pos(pos19), .proc_match_char(char19), .m_out(mout19), .valid_out(vo19),
        .m_in(zero512), .valid_in(zero1), .a_in(zero32), .b_in(zero32), .c_in(zero32), .d_in(zero32)
    );

    // ---------------- reference MD5 ----------------
    function automatic logic [31:0] md5_k(input int i);
        real x;
        x = $sin(real'(i + 1));
        if (x < 0.0) x = -x;
        return 32'(longint'($floor(x * 4294967296.0)));
    endfunction

    function automatic int md5_s(input int i);
        int q;
        q = i % 4;
        case (i / 16)
            0:       return (q == 0) ? 7 : (q == 1) ? 12 : (q == 2) ? 17 : 22;
            1:       return (q == 0) ? 5 : (q == 1) ? 9  : (q == 2) ? 14 : 20;
            2:       return (q == 0) ? 4 : (q == 1) ? 11 : (q == 2) ? 16 : 23;
            default: return (q == 0) ? 6 : (q == 1) ? 10 : (q == 2) ? 15 : 21;
        endcase
    endfunction

    // Returns the four chaining words {a, b, c, d} after one block.
    function automatic logic [127:0] md5_words(input logic [511:0] blk);
        logic [31:0] a, b, c, d, f, t;
        int g, sh;
        a = 32'h67452301; b = 32'hefcdab89; c = 32'h98badcfe; d = 32'h10325476;
        for (int i = 0; i < 64; i++) begin
            case (i / 16)
                0:       begin f = (b & c) | (~b & d); g = i;              end
                1:       begin f = (d & b) | (~d & c); g = (5 * i + 1) % 16; end
                2:       begin f = b ^ c ^ d;          g = (3 * i + 5) % 16; end
                default: begin f = c ^ (b | ~d);       g = (7 * i) % 16;     end
            endcase
            f  = f + a + md5_k(i) + blk[32 * g +: 32];
            sh = md5_s(i);
            t  = (f << sh) | (f >> (32 - sh));
            a = d; d = c; c = b; b = b + t;
        end
        return {32'h67452301 + a, 32'hefcdab89 + b, 32'h98badcfe + c, 32'h10325476 + d};
    endfunction

    // Digest as a byte string: each chaining word emitted least significant byte first.
    function automatic logic [127:0] digest_of(input logic [511:0] blk);
        logic [127:0] w, dg;
        w  = md5_words(blk);
        dg = '0;
        for (int k = 0; k < 16; k++) begin
            dg[127 - 8 * k -: 8] = w[127 - 32 * (k / 4) - 31 + 8 * (k % 4) +: 8];
        end
        return dg;
    endfunction

    function automatic logic [511:0] ref_block(input logic [7:0] s[$], input int st, input int len);
        logic [511:0] blk;
        blk = '0;
        for (int j = 0; j < len; j++) blk[8 * j +: 8] = s[st + j];
        blk[8 * len +: 8] = 8'h80;
        blk[511:448] = 64'(len * 8);
        return blk;
    endfunction

    function automatic void str2q(input string str, output logic [7:0] q[$]);
        q = {};
        for (int i = 0; i < str.len(); i++) q.push_back(str[i]);
    endfunction

    // ---------------- core model and block scoreboard ----------------
    logic [511:0] exp_q[$];
    logic [511:0] exp_blk;
    logic [511:0] last_blk = '0;
    logic         pv [LAT];
    logic [511:0] pm [LAT];
    logic [127:0] pw [LAT];
    int res_seen = 0, vo_count = 0, vo_first = 0, vo_last = 0, vo19_count = 0;

    initial begin
        for (int k = 0; k < LAT; k++) begin
            pv[k] = 1'b0; pm[k] = '0; pw[k] = '0;
        end
    end

    always @(negedge clk) begin
        if (vo3) begin
            checks++;
            assert (exp_q.size() != 0) else begin
                failures++;
                $error("FAIL blk_unexpected got=%0h want=none", mout3);
            end
            if (exp_q.size() != 0) begin
                exp_blk = exp_q.pop_front();
                checks++;
                assert (mout3 === exp_blk) else begin
                    failures++;
                    $error("FAIL blk_content got=%0h want=%0h", mout3, exp_blk);
                end
            end
            if (vo_count == 0) vo_first = cyc;
            vo_last  = cyc;
            vo_count = vo_count + 1;
            last_blk = mout3;
        end
        if (vo19) vo19_count = vo19_count + 1;
        for (int k = LAT - 1; k > 0; k--) begin
            pv[k] = pv[k - 1]; pm[k] = pm[k - 1]; pw[k] = pw[k - 1];
        end
        pv[0] = vo3;
        pm[0] = mout3;
        pw[0] = vo3 ? md5_words(mout3) : '0;
        vi3  = pv[LAT - 1];
        min3 = pm[LAT - 1];
        {a3, b3, c3, d3} = pw[LAT - 1];
        if (pv[LAT - 1]) res_seen = res_seen + 1;
    end

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s got=%0h want=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_run(input logic [7:0] s[$], input int nb, input bit gaps, input string tag);
        int exp_cnt, exp_pos, t;
        bit exp_match;
        logic [511:0] blk;
        exp_cnt   = (nb >= L3) ? nb - L3 + 1 : 0;
        exp_match = 1'b0;
        exp_pos   = 0;
        for (int w = 0; w < exp_cnt; w++) begin
            blk = ref_block(s, w, L3);
            exp_q.push_back(blk);
            if (!exp_match && digest_of(blk) == TARGET) begin
                exp_match = 1'b1;
                exp_pos   = w;
            end
        end
        res_seen = 0;
        vo_count = 0;
        start3 = 1'b1; nb3 = 16'(nb);
        tick();
        start3 = 1'b0;
        check({tag, "_done_cleared"}, done3, 1'b0);
        check({tag, "_match_cleared"}, match3, 1'b0);
        for (int j = 0; j < s.size(); j++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    dv3 = 1'b0;
                    tick();
                end
            end
            data3 = s[j]; dv3 = 1'b1;
            tick();
        end
        dv3 = 1'b0;
        t = 0;
        while (done3 !== 1'b1 && t < 400) begin
            tick();
            t++;
        end
        check({tag, "_done"}, done3, 1'b1);
        check({tag, "_results"}, res_seen, exp_cnt);
        check({tag, "_match"}, match3, exp_match);
        check({tag, "_pos"}, pos3, exp_match ? exp_pos : 0);
        check({tag, "_blocks_left"}, exp_q.size(), 0);
        if (exp_match) begin
            for (int k = 0; k <= L3; k++) begin
                check({tag, "_char"}, char3, s[exp_pos + (k % L3)]);
                next3 = 1'b1;
                tick();
                next3 = 1'b0;
            end
        end else begin
            check({tag, "_char_nomatch"}, char3, 8'h00);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [7:0] q[$];
        int len, extra, plant;

        repeat (3) tick();
        check("reset_done", done3, 1'b0);
        check("reset_match", match3, 1'b0);
        check("reset_pos", pos3, 16'h0);
        check("reset_char", char3, 8'h00);
        check("reset_valid_out", vo3, 1'b0);
        check("reset_m_out", mout3, 512'h0);
        rst = 1'b0;
        tick();

        str2q("abc", q);
        do_run(q, 3, 1'b0, "abc");

        // Short stream on the 19-byte engine finishes without issuing anything.
        start19 = 1'b1; nb19 = 16'd18;
        tick();
        start19 = 1'b0;
        check("short_done", done19, 1'b1);
        check("short_match", match19, 1'b0);
        for (int j = 0; j < 18; j++) begin
            data19 = 8'h61 + 8'(j); dv19 = 1'b1;
            tick();
        end
        dv19 = 1'b0;
        repeat (2) tick();
        check("short_no_blocks", vo19_count, 0);
        check("short_char", char19, 8'h00);

        str2q("xxabcx", q);
        do_run(q, 6, 1'b1, "xxabcx");

        str2q("abcabc", q);
        do_run(q, 6, 1'b0, "abcabc");

        // Back-to-back bytes: one block per cycle, length field 24 bits.
        q = {};
        for (int j = 0; j < 12; j++) q.push_back(8'h61 + 8'($urandom_range(0, 3)));
        do_run(q, 12, 1'b0, "b2b");
        check("b2b_count", vo_count, 10);
        check("b2b_contiguous", vo_last - vo_first + 1, 10);
        check("b2b_len_field", last_blk[511:448], 64'h18);

        // Reset at the 10th byte of a 100-byte run; window 4 holds "abc".
        q = {};
        for (int j = 0; j < 10; j++) q.push_back(8'h78 + 8'($urandom_range(0, 1)));
        q[4] = 8'h61; q[5] = 8'h62; q[6] = 8'h63;
        for (int w = 0; w < 6; w++) exp_q.push_back(ref_block(q, w, L3));
        start3 = 1'b1; nb3 = 16'd100;
        tick();
        start3 = 1'b0;
        for (int j = 0; j < 9; j++) begin
            data3 = q[j]; dv3 = 1'b1;
            tick();
        end
        data3 = q[9];
        rst = 1'b1;
        #1;
        check("abort_done", done3, 1'b0);
        check("abort_match", match3, 1'b0);
        check("abort_pos", pos3, 16'h0);
        check("abort_char", char3, 8'h00);
        check("abort_valid_out", vo3, 1'b0);
        check("abort_m_out", mout3, 512'h0);
        tick();
        rst = 1'b0;
        dv3 = 1'b0;
        repeat (80) tick();
        check("stale_match", match3, 1'b0);
        check("stale_done", done3, 1'b0);
        check("stale_pos", pos3, 16'h0);
        str2q("xyxyxyxabcyx", q);
        do_run(q, 12, 1'b1, "after_abort");

        // Randomised streams, some with a planted target and trailing junk.
        for (int r = 0; r < 6; r++) begin
            len   = $urandom_range(3, 24);
            extra = $urandom_range(0, 3);
            q = {};
            for (int j = 0; j < len + extra; j++) begin
                q.push_back((($urandom_range(0, 3)) == 3) ? 8'h78 : 8'h61 + 8'($urandom_range(0, 2)));
            end
            if ($urandom_range(0, 1) == 1) begin
                plant = $urandom_range(0, len - 3);
                q[plant] = 8'h61; q[plant + 1] = 8'h62; q[plant + 2] = 8'h63;
            end
            do_run(q, len, 1'b1, "random");
        end

        check("final_blocks_left", exp_q.size(), 0);
        check("final_short_no_blocks", vo19_count, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
